// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one master_spi between NUM_REQ requesters,
// with an idle gap after each transfer and a per-transfer timeout.
module spi_req_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk_m,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          timeout,
    output logic                          busy,
    output logic                          m_start,
    output logic [DATA_WIDTH-1:0]         m_data_in,
    input  logic                          m_finish,
    input  logic [DATA_WIDTH-1:0]         m_data_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [IW-1:0] LAST_INIT = IW'(NUM_REQ - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        GAP
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         last_q, last_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  to_q, to_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mstart_q, mstart_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [GW-1:0]         gcnt_q, gcnt_d;

    logic [DATA_WIDTH-1:0] word [NUM_REQ];
    logic                  pick_vld;
    logic [IW-1:0]         pick_idx;
    logic [IW-1:0]         cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
        assign word[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan starts just past the last served requester, wrapping modulo NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        to_d     = to_q;
        rdata_d  = rdata_q;
        mstart_d = 1'b0;
        mdata_d  = mdata_q;
        tcnt_d   = tcnt_q;
        gcnt_d   = gcnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    idx_d           = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    mdata_d         = word[pick_idx];
                    mstart_d        = 1'b1;
                    state_d         = START;
                end
            end
            START: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A finish landing on the terminal count still counts as success.
                if (m_finish) begin
                    rdata_d        = m_data_out;
                    done_d[idx_q]  = 1'b1;
                    last_d         = idx_q;
                    gcnt_d         = '0;
                    state_d        = GAP;
                end else if (tcnt_q == TO_LAST) begin
                    rdata_d        = '0;
                    done_d[idx_q]  = 1'b1;
                    to_d           = 1'b1;
                    last_d         = idx_q;
                    gcnt_d         = '0;
                    state_d        = GAP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            GAP: begin
                done_d = '0;
                to_d   = 1'b0;
                gnt_d  = '0;
                if (gcnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_m or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            last_q   <= LAST_INIT;
            gnt_q    <= '0;
            done_q   <= '0;
            to_q     <= 1'b0;
            rdata_q  <= '0;
            mstart_q <= 1'b0;
            mdata_q  <= '0;
            tcnt_q   <= '0;
            gcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            to_q     <= to_d;
            rdata_q  <= rdata_d;
            mstart_q <= mstart_d;
            mdata_q  <= mdata_d;
            tcnt_q   <= tcnt_d;
            gcnt_q   <= gcnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign timeout   = to_q;
    assign busy      = (state_q != IDLE);
    assign m_start   = mstart_q;
    assign m_data_in = mdata_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: vector table plus multi-cycle sequences,
// checked against a scoreboard of expected transfers.
module tb_spi_req_arbiter;

    localparam int DW      = 8;
    localparam int NR      = 4;
    localparam int GAP     = 2;
    localparam int TMO     = 255;

    logic            clk_m;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic [DW-1:0]   rdata;
    logic            timeout;
    logic            busy;
    logic            m_start;
    logic [DW-1:0]   m_data_in;
    logic            m_finish;
    logic [DW-1:0]   m_data_out;

    logic [DW-1:0]   wword [NR];

    spi_req_arbiter #(
        .DATA_WIDTH(DW),
        .NUM_REQ(NR),
        .GAP_CYCLES(GAP),
        .TIMEOUT(TMO)
    ) dut (
        .clk_m(clk_m),
        .rst(rst),
        .req(req),
        .wdata(wdata),
        .gnt(gnt),
        .done(done),
        .rdata(rdata),
        .timeout(timeout),
        .busy(busy),
        .m_start(m_start),
        .m_data_in(m_data_in),
        .m_finish(m_finish),
        .m_data_out(m_data_out)
    );

    assign wdata = {wword[3], wword[2], wword[1], wword[0]};

    initial begin
        clk_m = 1'b0;
        forever #5 clk_m = ~clk_m;
    end

    typedef struct {
        int        idx;
        logic [7:0] mdata;
        logic [7:0] rdata;
        logic       to;
    } exp_t;

    typedef struct {
        int         idx;
        logic [7:0] wd;
        int         lat;
        logic [7:0] key;
        logic [7:0] rd;
        logic       to;
    } vec_t;

    exp_t sb [$];

    int         n_vec = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         done_cyc = 0;
    int         last_done_cyc = 0;
    int         last_gap = 0;
    bit         have_done = 0;
    bit         saw_done = 0;
    int         mdl_lat = 0;
    logic [7:0] mdl_key = 8'h00;
    int         kick_n = 0;

    // Master model: pulses m_finish mdl_lat cycles after m_start (0 = never).
    initial begin
        int         pend;
        int         kseen;
        logic [7:0] rep;
        pend = 0;
        kseen = 0;
        rep = 8'h00;
        m_finish = 1'b0;
        m_data_out = 8'h00;
        forever begin
            @(negedge clk_m);
            m_finish = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (kick_n != kseen) begin
                    kseen = kick_n;
                    m_finish = 1'b1;
                    m_data_out = 8'hEE;
                end
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        m_finish = 1'b1;
                        m_data_out = rep;
                    end
                end
                if (m_start && mdl_lat > 0) begin
                    pend = mdl_lat;
                    rep = m_data_in ^ mdl_key;
                end
            end
        end
    end

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] v;
        v = '0;
        v[i[1:0]] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_m_start"}, 32'(m_start), 32'd0);
        chk({tag, "_m_data_in"}, 32'(m_data_in), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk_m);
        cyc++;
        if (!rst) begin
            if (m_start) begin
                start_cyc = cyc;
                if (have_done) begin
                    last_gap = cyc - last_done_cyc;
                    chk("start_gap_min", 32'(last_gap >= GAP + 2), 32'd1);
                end
                chk("start_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("m_data_in", 32'(m_data_in), 32'(sb[0].mdata));
                    chk("gnt_at_start", 32'(gnt), 32'(onehot(sb[0].idx)));
                end
            end
            if (done != '0) begin
                saw_done = 1;
                done_cyc = cyc;
                chk("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_vec", 32'(done), 32'(onehot(e.idx)));
                    chk("gnt_at_done", 32'(gnt), 32'(onehot(e.idx)));
                    chk("rdata", 32'(rdata), 32'(e.rdata));
                    chk("timeout_flag", 32'(timeout), 32'(e.to));
                end
                last_done_cyc = cyc;
                have_done = 1;
            end else if (timeout) begin
                chk("timeout_without_done", 32'(timeout), 32'd0);
            end
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        saw_done = 0;
        while (!saw_done && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, 32'(saw_done), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk("reach_idle", 32'(busy), 32'd0);
    endtask

    vec_t vt [7];
    exp_t e;

    initial begin
        vt[0] = '{2, 8'hA5, 20,  8'h99, 8'h3C, 1'b0};
        vt[1] = '{0, 8'h5A, 1,   8'h0F, 8'h55, 1'b0};
        vt[2] = '{3, 8'hC3, 0,   8'h00, 8'h00, 1'b1};
        vt[3] = '{0, 8'h77, 256, 8'hAA, 8'h00, 1'b1};
        vt[4] = '{1, 8'h12, 255, 8'h34, 8'h26, 1'b0};
        vt[5] = '{3, 8'hFF, 7,   8'hFF, 8'h00, 1'b0};
        vt[6] = '{1, 8'h00, 3,   8'h81, 8'h81, 1'b0};

        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NR; i++) wword[i] = 8'(8'h10 * i + 1);
        #1;
        chk_quiet("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single-requester vectors
        for (int i = 0; i < 7; i++) begin
            wait_idle();
            mdl_lat = vt[i].lat;
            mdl_key = vt[i].key;
            wword[vt[i].idx] = vt[i].wd;
            sb.push_back('{vt[i].idx, vt[i].wd, vt[i].rd, vt[i].to});
            req[vt[i].idx[1:0]] = 1'b1;
            tick();
            chk("start_latency", 32'(m_start), 32'd1);
            tick();
            chk("start_one_pulse", 32'(m_start), 32'd0);
            wait_done("vec", TMO + 20);
            req = '0;
            if (vt[i].to) chk("timeout_latency", 32'(done_cyc - start_cyc), 32'(TMO + 1));
            tick();
            chk("done_clears", 32'(done), 32'd0);
            chk("gnt_clears", 32'(gnt), 32'd0);
            chk("timeout_clears", 32'(timeout), 32'd0);
        end

        // Reset during WAIT
        wait_idle();
        mdl_lat = 0;
        wword[2] = 8'h6B;
        sb.push_back('{2, 8'h6B, 8'h00, 1'b0});
        req[2] = 1'b1;
        repeat (5) tick();
        chk("wait_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_quiet("async_rst");
        sb.delete();
        have_done = 0;
        req = '0;
        tick();
        rst = 1'b0;
        kick_n++;
        repeat (3) tick();
        chk("stray_finish_busy", 32'(busy), 32'd0);
        chk("stray_finish_rdata", 32'(rdata), 32'd0);

        // All four held: order 0,1,2,3,0 with minimum gap
        mdl_lat = 3;
        mdl_key = 8'h0F;
        wword[0] = 8'h11;
        wword[1] = 8'h22;
        wword[2] = 8'h33;
        wword[3] = 8'h44;
        for (int k = 0; k < 5; k++) begin
            sb.push_back('{k % 4, 8'(8'h11 * (k % 4 + 1)),
                           8'(8'h11 * (k % 4 + 1)) ^ 8'h0F, 1'b0});
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done("held", 60);
            if (k > 0) chk("held_gap", 32'(last_gap), 32'(GAP + 2));
        end
        req = '0;
        repeat (6) tick();
        chk("held_sb_empty", 32'(sb.size()), 32'd0);

        // Wrap-around: last_idx=1, then req=1001 serves 3 before 0
        wait_idle();
        mdl_lat = 2;
        mdl_key = 8'h00;
        wword[1] = 8'h5C;
        sb.push_back('{1, 8'h5C, 8'h5C, 1'b0});
        req[1] = 1'b1;
        wait_done("wrap_pre", 40);
        req = '0;
        wword[0] = 8'hE1;
        wword[3] = 8'h9C;
        sb.push_back('{3, 8'h9C, 8'h9C, 1'b0});
        sb.push_back('{0, 8'hE1, 8'hE1, 1'b0});
        req = 4'b1001;
        wait_done("wrap_first", 40);
        req[3] = 1'b0;
        wait_done("wrap_second", 40);
        req = '0;
        repeat (6) tick();
        chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
